// File: rtl/bootrom_arbiter_pkg.sv
// Shared types and helpers for the boot ROM arbiter: FSM states, the default ROM depth
// and the address window test.
package bootrom_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    localparam int unsigned ROM_WORDS_DEF = 64;

    // The whole address takes part in the test, so nonzero upper bits are always outside the window.
    function automatic logic addr_out_of_window(input logic [63:0] addr, input int unsigned rom_words);
        return addr >= (64'(rom_words) << 2);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority rotate: grants the first request found by
// searching upward from the pointer and wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [PW-1:0]   idx_o
);

    always_comb begin : search
        int unsigned cand;
        logic        found;
        cand  = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = (32'(ptr_i) + i) % NREQ;
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = PW'(cand);
            end
        end
    end

endmodule

// File: rtl/bootrom_arbiter.sv
// Round-robin arbiter sharing one combinational boot ROM between NREQ fetch ports;
// one access per grant, registered read data and a one-cycle ack/err pulse.
module bootrom_arbiter
    import bootrom_arbiter_pkg::*;
#(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned NREQ      = 2,
    parameter int unsigned ROM_WORDS = ROM_WORDS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    input  logic [NREQ*DW-1:0]   req_din_i,
    input  logic [NREQ-1:0]      req_en_i,
    input  logic [NREQ-1:0]      req_we_i,
    output logic [NREQ*DW-1:0]   req_dout_o,
    output logic [NREQ-1:0]      req_ack_o,
    output logic [NREQ-1:0]      req_err_o,
    output logic [AW-1:0]        rom_addr_o,
    output logic [DW-1:0]        rom_din_o,
    output logic                 rom_en_o,
    output logic                 rom_we_o,
    input  logic [DW-1:0]        rom_dout_i
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e                  state_q, state_d;
    logic [PW-1:0]           ptr_q, ptr_d;
    logic [PW-1:0]           gidx_q, gidx_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic                    err_q, err_d;
    logic                    rom_en_q, rom_en_d;
    logic [NREQ-1:0]         ack_q, ack_d;
    logic [NREQ-1:0]         rerr_q, rerr_d;
    logic [NREQ-1:0][DW-1:0] dout_q, dout_d;

    logic [NREQ-1:0]         arb_gnt;
    logic [PW-1:0]           arb_idx;
    logic                    unused_din;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i (req_en_i),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx)
    );

    // The write qualifier is folded into the error flag at grant time; a latched
    // error is the only thing ACCESS/RESP need to know about it.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gidx_d   = gidx_q;
        addr_d   = addr_q;
        err_d    = err_q;
        rom_en_d = 1'b0;
        ack_d    = '0;
        rerr_d   = '0;
        dout_d   = dout_q;
        unique case (state_q)
            IDLE: begin
                if (|arb_gnt) begin
                    gidx_d   = arb_idx;
                    addr_d   = req_addr_i[32'(arb_idx) * AW +: AW];
                    err_d    = req_we_i[arb_idx] | addr_out_of_window(64'(addr_d), ROM_WORDS);
                    rom_en_d = ~err_d;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                if (rom_en_q) begin
                    dout_d[gidx_q] = rom_dout_i;
                end
                ack_d[gidx_q]  = 1'b1;
                rerr_d[gidx_q] = err_q;
                state_d        = RESP;
            end
            RESP: begin
                ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            rom_en_q <= 1'b0;
            ack_q    <= '0;
            rerr_q   <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gidx_q   <= gidx_d;
            addr_q   <= addr_d;
            err_q    <= err_d;
            rom_en_q <= rom_en_d;
            ack_q    <= ack_d;
            rerr_q   <= rerr_d;
            dout_q   <= dout_d;
        end
    end

    assign req_dout_o = dout_q;
    assign req_ack_o  = ack_q;
    assign req_err_o  = rerr_q;
    assign rom_addr_o = addr_q;
    assign rom_en_o   = rom_en_q;
    assign rom_din_o  = '0;
    assign rom_we_o   = 1'b0;
    assign unused_din = ^req_din_i;

endmodule

// File: tb/tb_bootrom_arbiter.sv
// Bench for bootrom_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic against a transaction-level reference model.
module tb_bootrom_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ROM contents: word 2 is a fixed pattern, everything else encodes its index
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        logic [5:0] w;
        w = a[7:2];
        return (w == 6'd2) ? 32'h1234_5678 : (32'hC0DE_0000 | 32'(w));
    endfunction

    // Two-requester instance
    logic [63:0] a_addr = '0, a_din = '0, a_dout;
    logic [1:0]  a_en = '0, a_we = '0, a_ack, a_err;
    logic [31:0] a_raddr, a_rdin, a_rdata;
    logic        a_ren, a_rwe;
    assign a_rdata = rom_word(a_raddr);

    bootrom_arbiter #(.NREQ(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_addr_i(a_addr), .req_din_i(a_din), .req_en_i(a_en), .req_we_i(a_we),
        .req_dout_o(a_dout), .req_ack_o(a_ack), .req_err_o(a_err),
        .rom_addr_o(a_raddr), .rom_din_o(a_rdin), .rom_en_o(a_ren), .rom_we_o(a_rwe),
        .rom_dout_i(a_rdata)
    );

    // Three-requester instance for pointer wrap
    logic [95:0] b_addr = '0, b_din = '0, b_dout;
    logic [2:0]  b_en = '0, b_we = '0, b_ack, b_err;
    logic [31:0] b_raddr, b_rdin, b_rdata;
    logic        b_ren, b_rwe;
    assign b_rdata = rom_word(b_raddr);

    bootrom_arbiter #(.NREQ(3)) dut_b (
        .clk(clk), .rst(rst),
        .req_addr_i(b_addr), .req_din_i(b_din), .req_en_i(b_en), .req_we_i(b_we),
        .req_dout_o(b_dout), .req_ack_o(b_ack), .req_err_o(b_err),
        .rom_addr_o(b_raddr), .rom_din_o(b_rdin), .rom_en_o(b_ren), .rom_we_o(b_rwe),
        .rom_dout_i(b_rdata)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One full transaction on dut_a, entered and left just after a falling edge in IDLE.
    task automatic round2(input logic [1:0] en, input logic [1:0] we,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input int g, input logic e,
                          input logic [31:0] d0, input logic [31:0] d1);
        logic [1:0] oh;
        oh    = 2'b00;
        oh[g] = 1'b1;
        a_en   = en;
        a_we   = we;
        a_addr = {a1, a0};
        @(negedge clk);
        chk("rom_en_access", a_ren, !e);
        chk("rom_we", a_rwe, 0);
        chk("rom_din", a_rdin, 0);
        chk("ack_early", a_ack, 0);
        if (!e) chk("rom_addr", a_raddr, (g == 1) ? a1 : a0);
        @(negedge clk);
        chk("ack", a_ack, oh);
        chk("err", a_err, e ? oh : 2'b00);
        chk("dout0", a_dout[31:0], d0);
        chk("dout1", a_dout[63:32], d1);
        chk("rom_en_resp", a_ren, 0);
        a_en[g] = 1'b0;
        @(negedge clk);
        chk("ack_pulse", a_ack, 0);
        chk("err_pulse", a_err, 0);
    endtask

    typedef struct {
        logic [1:0]  en;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        int          g;
        logic        e;
        logic [31:0] d0;
        logic [31:0] d1;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'h100 + $urandom_range(0, 255);
            default: return 32'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        tbl[0]  = '{2'b01, 2'b00, 32'h08,        32'h00, 0, 1'b0, 32'h1234_5678, 32'h0000_0000};
        tbl[1]  = '{2'b11, 2'b00, 32'h00,        32'h04, 1, 1'b0, 32'h1234_5678, 32'hC0DE_0001};
        tbl[2]  = '{2'b11, 2'b00, 32'h00,        32'h04, 0, 1'b0, 32'hC0DE_0000, 32'hC0DE_0001};
        tbl[3]  = '{2'b10, 2'b00, 32'h00,        32'h04, 1, 1'b0, 32'hC0DE_0000, 32'hC0DE_0001};
        tbl[4]  = '{2'b10, 2'b10, 32'h00,        32'h00, 1, 1'b1, 32'hC0DE_0000, 32'hC0DE_0001};
        tbl[5]  = '{2'b01, 2'b00, 32'h100,       32'h00, 0, 1'b1, 32'hC0DE_0000, 32'hC0DE_0001};
        tbl[6]  = '{2'b01, 2'b00, 32'h8000_0000, 32'h00, 0, 1'b1, 32'hC0DE_0000, 32'hC0DE_0001};
        tbl[7]  = '{2'b10, 2'b00, 32'h00,        32'hFF, 1, 1'b0, 32'hC0DE_0000, 32'hC0DE_003F};
        tbl[8]  = '{2'b01, 2'b00, 32'h0B,        32'h00, 0, 1'b0, 32'h1234_5678, 32'hC0DE_003F};
        tbl[9]  = '{2'b11, 2'b01, 32'h10,        32'h14, 1, 1'b0, 32'h1234_5678, 32'hC0DE_0005};
        tbl[10] = '{2'b11, 2'b01, 32'h10,        32'h14, 0, 1'b1, 32'h1234_5678, 32'hC0DE_0005};
        tbl[11] = '{2'b10, 2'b00, 32'h00,        32'h14, 1, 1'b0, 32'h1234_5678, 32'hC0DE_0005};

        // Reset state
        #1;
        chk("rst_ack", a_ack, 0);
        chk("rst_err", a_err, 0);
        chk("rst_dout", a_dout, 0);
        chk("rst_rom_en", a_ren, 0);
        chk("rst_rom_addr", a_raddr, 0);
        chk("rst_b_ack", b_ack, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        foreach (tbl[i])
            round2(tbl[i].en, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].g, tbl[i].e, tbl[i].d0, tbl[i].d1);

        // Address and write qualifier change after grant must be ignored
        a_en = 2'b01; a_we = 2'b00; a_addr = {32'h0, 32'h10};
        @(negedge clk);
        a_addr = {32'h0, 32'h0C}; a_we = 2'b01;
        chk("latch_rom_addr", a_raddr, 32'h10);
        chk("latch_rom_en", a_ren, 1);
        @(negedge clk);
        chk("latch_ack", a_ack, 2'b01);
        chk("latch_err", a_err, 2'b00);
        chk("latch_dout0", a_dout[31:0], 32'hC0DE_0004);
        a_en = 2'b00; a_we = 2'b00;
        @(negedge clk);

        // Enable dropped during the access still completes
        a_en = 2'b10; a_addr = {32'h18, 32'h0};
        @(negedge clk);
        a_en = 2'b00;
        @(negedge clk);
        chk("drop_ack", a_ack, 2'b10);
        chk("drop_dout1", a_dout[63:32], 32'hC0DE_0006);
        @(negedge clk);
        chk("drop_ack_gone", a_ack, 0);

        // Reset in the middle of an access
        a_en = 2'b01; a_addr = {32'h0, 32'h0};
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_ack", a_ack, 0);
        chk("mid_rst_dout", a_dout, 0);
        chk("mid_rst_rom_en", a_ren, 0);
        chk("mid_rst_rom_addr", a_raddr, 0);
        a_en = 2'b00;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("mid_rst_no_ack", a_ack, 0);
        end
        round2(2'b11, 2'b00, 32'h04, 32'h08, 0, 1'b0, 32'hC0DE_0001, 32'h0000_0000);
        round2(2'b10, 2'b00, 32'h04, 32'h08, 1, 1'b0, 32'hC0DE_0001, 32'h1234_5678);

        // Three requesters held active: grants 0,1,2 then wrap to 0
        b_en = 3'b111; b_addr = {32'h08, 32'h04, 32'h00};
        for (int k = 0; k < 4; k++) begin
            logic [2:0] oh;
            int         g;
            g     = k % 3;
            oh    = 3'b000;
            oh[g] = 1'b1;
            @(negedge clk);
            @(negedge clk);
            chk("wrap_ack", b_ack, oh);
            chk("wrap_dout", b_dout[32*g +: 32], rom_word(32'(4 * g)));
            @(negedge clk);
            chk("wrap_ack_gone", b_ack, 0);
        end
        b_en = 3'b000;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Randomized traffic against a transaction-level model
        begin
            logic        pend_en[2];
            logic        pend_we[2];
            logic [31:0] pend_addr[2];
            logic [31:0] md[2];
            int          waits[2];
            int          mptr;
            pend_en = '{1'b0, 1'b0};
            pend_we = '{1'b0, 1'b0};
            pend_addr = '{32'h0, 32'h0};
            md = '{32'hC0DE_0001, 32'h1234_5678};
            waits = '{0, 0};
            mptr = 0;
            for (int r = 0; r < 300; r++) begin
                int   g;
                logic e;
                for (int i = 0; i < 2; i++) begin
                    if (!pend_en[i] && ($urandom_range(0, 1) == 1)) begin
                        pend_en[i]   = 1'b1;
                        pend_we[i]   = ($urandom_range(0, 3) == 0);
                        pend_addr[i] = rand_addr();
                    end
                end
                if (!pend_en[0] && !pend_en[1]) begin
                    a_en = 2'b00;
                    @(negedge clk);
                    chk("rand_idle_ack", a_ack, 0);
                    continue;
                end
                g = -1;
                for (int k = 0; k < 2; k++)
                    if (g < 0 && pend_en[(mptr + k) % 2]) g = (mptr + k) % 2;
                e = pend_we[g] || (pend_addr[g] > 32'd255);
                if (!e) md[g] = rom_word(pend_addr[g]);
                round2({pend_en[1], pend_en[0]}, {pend_we[1], pend_we[0]},
                       pend_addr[0], pend_addr[1], g, e, md[0], md[1]);
                pend_en[g] = 1'b0;
                waits[g]   = 0;
                waits[1 - g] = pend_en[1 - g] ? waits[1 - g] + 1 : 0;
                chk("rand_fair", waits[1 - g] > 1, 0);
                mptr = (g + 1) % 2;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
